trace_plotter: RTL and testbench



---
 rtl/trace_plotter.sv | 225 ++++++++++++++++++++++
 tb/tb_trace_plotter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_plotter.sv
// Converts (v1, v2) samples to screen rows and plots one pixel per trace over the Avalon master.
// Build option: define TRACE_PLOTTER_ERASE_EN to erase the previous pass's pixels before drawing.
module trace_plotter #(
  parameter logic [31:0] VIDEO_BASE = 32'h0800_0000,
  parameter int          X_MAX      = 639,
  parameter int          Y_MAX      = 479,
  parameter int          SHIFT      = 12,
  parameter int          Y_OFFSET1  = 120,
  parameter int          Y_OFFSET2  = 360,
  parameter logic [7:0]  COLOR1     = 8'hFF,
  parameter logic [7:0]  COLOR2     = 8'h1C
`ifdef TRACE_PLOTTER_ERASE_EN
  , parameter logic [7:0] BG_COLOR  = 8'h00
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [17:0] v1,
  input  logic [17:0] v2,
  input  logic        vga_hs,
  input  logic        vga_vs,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_write,
  output logic [31:0] bus_write_data,
  input  logic        bus_ack,
  output logic [9:0]  x_coord,
  output logic        column_done
);

  localparam int unsigned SAMPLE_W = 18;
  localparam int unsigned CALC_W   = 20;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned ADDR_W   = 32;

  typedef enum logic [3:0] {
    IDLE, SCALE, DRAW1, WAIT1, DRAW2, WAIT2, ADVANCE
`ifdef TRACE_PLOTTER_ERASE_EN
    , ERASE1, EWAIT1, ERASE2, EWAIT2
`endif
  } state_t;

  state_t                     state_q, state_d;
  logic signed [SAMPLE_W-1:0] v1_q, v2_q, v1_d, v2_d;
  logic [COORD_W-1:0]         y1_q, y2_q, y1_d, y2_d, x_d;
  logic [ADDR_W-1:0]          addr_d, data_d;
  logic                       write_d, ready_d, done_d, window_open;

  // Signed offset + arithmetic shift, clamped to the visible rows
  function automatic logic [COORD_W-1:0] scale_row(input logic signed [SAMPLE_W-1:0] v,
                                                   input int offset);
    logic signed [CALC_W-1:0] y;
    y = CALC_W'(offset) + (CALC_W'(v) >>> SHIFT);
    if (y < 0)                   return '0;
    else if (y > CALC_W'(Y_MAX)) return COORD_W'(Y_MAX);
    else                         return COORD_W'(y);
  endfunction

  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
    return VIDEO_BASE + ADDR_W'(x) + (ADDR_W'(y) << 10);
  endfunction

`ifdef TRACE_PLOTTER_ERASE_EN
  logic                wrapped_q, wrapped_d;
  logic [COORD_W-1:0]  hist1 [0:X_MAX];
  logic [COORD_W-1:0]  hist2 [0:X_MAX];

  // Row history of the pass being overwritten; contents are only trusted once wrapped
  always_ff @(posedge clock) begin
    if (state_q == ADVANCE) begin
      hist1[x_coord] <= y1_q;
      hist2[x_coord] <= y2_q;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    x_d         = x_coord;
    addr_d      = bus_addr;
    data_d      = bus_write_data;
    write_d     = bus_write;
`ifdef TRACE_PLOTTER_ERASE_EN
    wrapped_d   = wrapped_q;
`endif
    window_open = ~vga_vs | ~vga_hs;

    case (state_q)
      IDLE: begin
        if (sample_valid && sample_ready) begin
          v1_d    = $signed(v1);
          v2_d    = $signed(v2);
          state_d = SCALE;
        end
      end
      SCALE: begin
        y1_d    = scale_row(v1_q, Y_OFFSET1);
        y2_d    = scale_row(v2_q, Y_OFFSET2);
`ifdef TRACE_PLOTTER_ERASE_EN
        state_d = wrapped_q ? ERASE1 : DRAW1;
`else
        state_d = DRAW1;
`endif
      end
`ifdef TRACE_PLOTTER_ERASE_EN
      ERASE1: begin
        if (window_open) begin
          addr_d  = pixel_addr(x_coord, hist1[x_coord]);
          data_d  = {24'b0, BG_COLOR};
          write_d = 1'b1;
          state_d = EWAIT1;
        end
      end
      EWAIT1: begin
        if (bus_ack) begin
          write_d = 1'b0;
          state_d = ERASE2;
        end
      end
      ERASE2: begin
        if (window_open) begin
          addr_d  = pixel_addr(x_coord, hist2[x_coord]);
          data_d  = {24'b0, BG_COLOR};
          write_d = 1'b1;
          state_d = EWAIT2;
        end
      end
      EWAIT2: begin
        if (bus_ack) begin
          write_d = 1'b0;
          state_d = DRAW1;
        end
      end
`endif
      DRAW1: begin
        if (window_open) begin
          addr_d  = pixel_addr(x_coord, y1_q);
          data_d  = {24'b0, COLOR1};
          write_d = 1'b1;
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (bus_ack) begin
          write_d = 1'b0;
          state_d = DRAW2;
        end
      end
      DRAW2: begin
        if (window_open) begin
          addr_d  = pixel_addr(x_coord, y2_q);
          data_d  = {24'b0, COLOR2};
          write_d = 1'b1;
          state_d = WAIT2;
        end
      end
      WAIT2: begin
        if (bus_ack) begin
          write_d = 1'b0;
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if (x_coord == COORD_W'(X_MAX)) begin
          x_d = '0;
`ifdef TRACE_PLOTTER_ERASE_EN
          wrapped_d = 1'b1;
`endif
        end else begin
          x_d = x_coord + COORD_W'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake and pulse outputs are registered copies of the upcoming state
    ready_d = (state_d == IDLE);
    done_d  = (state_d == ADVANCE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      v1_q           <= '0;
      v2_q           <= '0;
      y1_q           <= '0;
      y2_q           <= '0;
      x_coord        <= '0;
      bus_addr       <= VIDEO_BASE;
      bus_write_data <= '0;
      bus_write      <= 1'b0;
      sample_ready   <= 1'b1;
      column_done    <= 1'b0;
`ifdef TRACE_PLOTTER_ERASE_EN
      wrapped_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      y1_q           <= y1_d;
      y2_q           <= y2_d;
      x_coord        <= x_d;
      bus_addr       <= addr_d;
      bus_write_data <= data_d;
      bus_write      <= write_d;
      sample_ready   <= ready_d;
      column_done    <= done_d;
`ifdef TRACE_PLOTTER_ERASE_EN
      wrapped_q      <= wrapped_d;
`endif
    end
  end

  assign bus_byte_enable = 4'b0001;

endmodule

// File: tb/tb_trace_plotter.sv
// Directed + randomized bench for trace_plotter: two instances (default offsets, and
// offsets 470/0 that reach both clamps) checked against an arithmetic row/address model.
module tb_trace_plotter;

  localparam int OFF1_A = 120;
  localparam int OFF2_A = 360;
  localparam int OFF1_B = 470;
  localparam int OFF2_B = 0;

  logic        clock = 1'b0;
  logic        reset, sample_valid, vga_hs, vga_vs, bus_ack;
  logic [17:0] v1, v2;

  logic        ready_a, write_a, done_a, ready_b, write_b, done_b;
  logic [31:0] addr_a, data_a, addr_b, data_b;
  logic [3:0]  be_a, be_b;
  logic [9:0]  x_a, x_b;

  int passed = 0;
  int total  = 0;
  int exp_x  = 0;

  trace_plotter u_a (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_ready(ready_a),
    .v1(v1), .v2(v2), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .bus_addr(addr_a), .bus_byte_enable(be_a), .bus_write(write_a),
    .bus_write_data(data_a), .bus_ack(bus_ack), .x_coord(x_a), .column_done(done_a)
  );

  trace_plotter #(.Y_OFFSET1(OFF1_B), .Y_OFFSET2(OFF2_B)) u_b (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_ready(ready_b),
    .v1(v1), .v2(v2), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .bus_addr(addr_b), .bus_byte_enable(be_b), .bus_write(write_b),
    .bus_write_data(data_b), .bus_ack(bus_ack), .x_coord(x_b), .column_done(done_b)
  );

  always #10 clock = ~clock;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Row = offset + floor(v / 4096), clamped to [0, 479]
  function automatic int exp_row(input logic [17:0] v, input int off);
    int s, q, y;
    s = v[17] ? int'(v) - 262144 : int'(v);
    q = (s >= 0) ? s / 4096 : -((-s + 4095) / 4096);
    y = off + q;
    if (y < 0)   y = 0;
    if (y > 479) y = 479;
    return y;
  endfunction

  function automatic logic [31:0] pix(input int x, input int row);
    return 32'h0800_0000 + 32'(x) + 32'(row * 1024);
  endfunction

  task automatic wait_write(input string tag, output int n);
    n = 0;
    while (!write_a && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " write seen"}, 32'(write_a), 32'd1);
  endtask

  task automatic do_write(input string tag, input int lat_exp, input logic [31:0] ea,
                          input logic [31:0] eb, input logic [7:0] color, input int ack_dly);
    int n;
    wait_write(tag, n);
    if (lat_exp >= 0) chk({tag, " latency"}, 32'(n), 32'(lat_exp));
    chk({tag, " addr a"}, addr_a, ea);
    chk({tag, " addr b"}, addr_b, eb);
    chk({tag, " data a"}, data_a, {24'b0, color});
    chk({tag, " data b"}, data_b, {24'b0, color});
    chk({tag, " byte_en"}, 32'({be_a, be_b}), 32'h11);
    chk({tag, " ready low while writing"}, 32'({ready_a, ready_b}), 32'd0);
    repeat (ack_dly) @(negedge clock);
    if (ack_dly > 0) begin
      chk({tag, " held write"}, 32'({write_a, write_b}), 32'd3);
      chk({tag, " held addr"}, addr_a, ea);
    end
    bus_ack = 1'b1;
    @(negedge clock);
    bus_ack = 1'b0;
    chk({tag, " released"}, 32'({write_a, write_b}), 32'd0);
  endtask

  task automatic do_sample(input logic [17:0] a, input logic [17:0] b,
                           input int closed, input int ack_dly);
    int r;
    logic any_wr;
    chk("ready idle", 32'({ready_a, ready_b}), 32'd3);
    v1 = a;
    v2 = b;
    sample_valid = 1'b1;
    r = int'($urandom_range(0, 2));
    if (closed > 0)  {vga_hs, vga_vs} = 2'b11;
    else if (r == 0) {vga_hs, vga_vs} = 2'b00;
    else if (r == 1) {vga_hs, vga_vs} = 2'b01;
    else             {vga_hs, vga_vs} = 2'b10;
    @(negedge clock);
    sample_valid = 1'b0;
    chk("ready busy", 32'({ready_a, ready_b}), 32'd0);
    if (closed > 0) begin
      any_wr = 1'b0;
      repeat (closed) begin
        @(negedge clock);
        any_wr = any_wr | write_a | write_b;
      end
      chk("closed window no write", 32'(any_wr), 32'd0);
      vga_hs = 1'b0;
      @(negedge clock);
      chk("window open rise", 32'({write_a, write_b}), 32'd3);
    end
    do_write("w1", (closed > 0) ? 0 : 2, pix(exp_x, exp_row(a, OFF1_A)),
             pix(exp_x, exp_row(a, OFF1_B)), 8'hFF, ack_dly);
    do_write("w2", 1, pix(exp_x, exp_row(b, OFF2_A)),
             pix(exp_x, exp_row(b, OFF2_B)), 8'h1C, ack_dly);
    chk("column_done", 32'({done_a, done_b}), 32'd3);
    @(negedge clock);
    chk("column_done pulse", 32'({done_a, done_b}), 32'd0);
    exp_x = (exp_x == 639) ? 0 : exp_x + 1;
    chk("x_coord a", 32'(x_a), 32'(exp_x));
    chk("x_coord b", 32'(x_b), 32'(exp_x));
  endtask

  function automatic logic [17:0] rand_sample();
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) return 18'h1_FFFF;
    if (k == 1) return 18'h2_0000;
    if (k == 2) return 18'h0_0000;
    return 18'($urandom());
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    sample_valid = 1'b0;
    bus_ack = 1'b0;
    vga_hs = 1'b1;
    vga_vs = 1'b1;
    v1 = '0;
    v2 = '0;
    repeat (2) @(negedge clock);
    chk("rst ready", 32'({ready_a, ready_b}), 32'd3);
    chk("rst write", 32'({write_a, write_b}), 32'd0);
    chk("rst data", data_a, 32'd0);
    chk("rst addr", addr_a, 32'h0800_0000);
    chk("rst x", 32'({x_a, x_b}), 32'd0);
    chk("rst done", 32'({done_a, done_b}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Reference sample: rows 112 and 368 on the default instance
    do_sample(18'h3_8000, 18'h0_8000, 0, 1);
    // Closed sync window for 50 cycles before the first write
    do_sample(18'h0_1000, 18'h3_F000, 50, 0);
    // Clamp corners on instance b (470 + 16 -> 479, 0 - 32 -> 0)
    do_sample(18'h1_0000, 18'h2_0000, 0, 0);
    do_sample(18'h2_0000, 18'h1_FFFF, 0, 2);
    do_sample(18'h1_FFFF, 18'h0_0FFF, 0, 1);

    for (int i = 0; i < 25; i++)
      do_sample(rand_sample(), rand_sample(), 0, int'($urandom_range(0, 3)));

    // Reset while the first write waits for an ack that never comes
    v1 = 18'h0_4000;
    v2 = 18'h3_C000;
    sample_valid = 1'b1;
    {vga_hs, vga_vs} = 2'b00;
    @(negedge clock);
    sample_valid = 1'b0;
    wait_write("rst mid", n);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid rst write", 32'({write_a, write_b}), 32'd0);
    chk("mid rst x", 32'({x_a, x_b}), 32'd0);
    chk("mid rst ready", 32'({ready_a, ready_b}), 32'd3);
    exp_x = 0;
    bus_ack = 1'b1;
    @(negedge clock);
    bus_ack = 1'b0;
    chk("late ack ignored write", 32'({write_a, write_b}), 32'd0);
    chk("late ack ignored ready", 32'({ready_a, ready_b}), 32'd3);
    @(negedge clock);

    // Full pass plus one: column wraps back to 0
    for (int i = 0; i < 641; i++)
      do_sample(rand_sample(), rand_sample(), 0, int'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
